// File: rtl/bcd_count_scan.sv
// Four-digit BCD up/down counter with a time-multiplexed digit scanner.
// Each scan slot drives one BCD nibble and an active-low one-hot anode.
module bcd_count_scan #(
  parameter int CNT_DIV  = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up_dn,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        blank_lz,
  output logic [15:0] count_val,
  output logic [3:0]  bcd_out,
  output logic [3:0]  dig_an,
  output logic        wrap,
  output logic        load_err
);

  localparam int TW = (CNT_DIV  > 1) ? $clog2(CNT_DIV)  : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_scan_idx;
  logic [15:0]   r_count;
  logic [3:0]    r_bcd_out;
  logic [3:0]    r_dig_an;
  logic          r_wrap;
  logic          r_load_err;

  logic          w_tick;
  logic          w_scan_last;
  logic [16:0]   w_step;
  logic [15:0]   w_load_fix;
  logic          w_load_bad;
  logic [3:0]    w_hi_zero;
  logic          w_blank;
  logic [3:0]    w_digit;

  // Ripple carry/borrow across digits; bit 16 is the carry-out that marks a wrap.
  function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] res;
    logic        c;
    res = v;
    c   = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (up) begin
          if (v[4*d +: 4] == 4'd9) res[4*d +: 4] = 4'd0;
          else begin res[4*d +: 4] = v[4*d +: 4] + 4'd1; c = 1'b0; end
        end else begin
          if (v[4*d +: 4] == 4'd0) res[4*d +: 4] = 4'd9;
          else begin res[4*d +: 4] = v[4*d +: 4] - 4'd1; c = 1'b0; end
        end
      end
    end
    return {c, res};
  endfunction

  assign w_tick      = en && (r_tick_cnt == TW'(CNT_DIV - 1));
  assign w_scan_last = (r_scan_cnt == SW'(SCAN_DIV - 1));
  assign w_step      = bcd_step(r_count, up_dn);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_load_fix = '0;
    w_load_bad = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (load_val[4*d +: 4] > 4'd9) w_load_bad = 1'b1;
      else                           w_load_fix[4*d +: 4] = load_val[4*d +: 4];
    end
  end

  assign w_hi_zero[3] = (r_count[15:12] == 4'd0);
  assign w_hi_zero[2] = w_hi_zero[3] && (r_count[11:8] == 4'd0);
  assign w_hi_zero[1] = w_hi_zero[2] && (r_count[7:4]  == 4'd0);
  assign w_hi_zero[0] = 1'b0;
  assign w_blank      = blank_lz && w_hi_zero[r_scan_idx];
  assign w_digit      = r_count[{r_scan_idx, 2'b00} +: 4];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      if (clr) begin
        r_count    <= '0;
        r_tick_cnt <= '0;
      end else if (load) begin
        r_count    <= w_load_fix;
        r_load_err <= w_load_bad;
        r_tick_cnt <= '0;
      end else begin
        if (en) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        if (w_tick) begin
          r_count <= w_step[15:0];
          r_wrap  <= w_step[16];
        end
      end
    end
  end

  // Scanner free-runs regardless of en/clr/load; display regs follow the live count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_idx <= 2'd0;
      r_bcd_out  <= 4'd0;
      r_dig_an   <= 4'b1110;
    end else begin
      r_scan_cnt <= w_scan_last ? '0 : r_scan_cnt + 1'b1;
      if (w_scan_last) r_scan_idx <= r_scan_idx + 2'd1;
      r_bcd_out  <= w_blank ? 4'd0    : w_digit;
      r_dig_an   <= w_blank ? 4'b1111 : ~(4'b0001 << r_scan_idx);
    end
  end

  assign count_val = r_count;
  assign bcd_out   = r_bcd_out;
  assign dig_an    = r_dig_an;
  assign wrap      = r_wrap;
  assign load_err  = r_load_err;

endmodule

// File: doc/bcd_count_scan.md
Name: bcd_count_scan

Overview:
- Four-digit BCD up/down counter (0000-9999) with a time-multiplexed digit scanner.
- Sits directly upstream of the team's BCD-to-7-segment decoder. Each scan slot presents one BCD nibble (bcd_out[3]=A … bcd_out[0]=D) plus an active-low one-hot anode select.
- One decoder instance can therefore drive a 4-digit common-anode display.

Parameters:
- CNT_DIV, 50000000, clk cycles per count tick; legal range >=1.
- SCAN_DIV, 50000, clk cycles per scan slot; legal range >=1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; the tick prescaler also advances only when en=1.
- up_dn  input  1  1 = count up, 0 = count down.
- clr  input  1  synchronous clear of the count to 0000.
- load  input  1  synchronous load of load_val.
- load_val  input  16  four BCD digits; [15:12] is the thousands digit.
- blank_lz  input  1  1 = blank leading-zero digits.
- count_val  output  16  current count, BCD, registered.
- bcd_out  output  4  nibble for the active scan slot, registered.
- dig_an  output  4  anode select, active-low one-hot; 1111 = blank.
- wrap  output  1  one-cycle pulse on 9999->0000 (up) or 0000->9999 (down).
- load_err  output  1  one-cycle pulse when a loaded nibble was >9.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count_val=0000, bcd_out=0000, dig_an=1110, wrap=0, load_err=0.
  - Both prescalers and the scan index are 0.
  - Leaving reset is synchronous to the next clk edge.
- Tick prescaler:
  - tick_cnt counts 0..CNT_DIV-1 while en=1, then wraps; it holds when en=0.
  - The internal tick is asserted in the cycle where tick_cnt==CNT_DIV-1 and en=1.
  - CNT_DIV=1 gives a tick every enabled cycle.
  - clr and load also zero tick_cnt.
- Count priority (per clk): clr > load > tick > hold.
  - clr: count_val<=0000. No wrap pulse.
  - load: each nibble of load_val with value <=9 is taken as-is; any nibble >9 is replaced by 0. load_err pulses for one cycle if any nibble was >9. No wrap pulse.
  - tick with up_dn=1: BCD increment with ripple carry (digit 9 -> 0 carries). 9999 -> 0000 and wrap=1 for one cycle.
  - tick with up_dn=0: BCD decrement with ripple borrow (digit 0 -> 9 borrows). 0000 -> 9999 and wrap=1 for one cycle.
  - The count update is visible on count_val the cycle after the tick. wrap and load_err are registered and aligned with that count_val update.
- Scan:
  - scan_cnt runs 0..SCAN_DIV-1 continuously and is independent of en, clr and load.
  - On wrap, the 2-bit index advances 0->1->2->3->0.
  - Index i selects digit i (0 = units). dig_an has bit i low.
  - bcd_out = count_val nibble i, and is registered together with dig_an. Outputs change one cycle after the index changes and always reflect the current count_val.
- Blanking:
  - When blank_lz=1, digit i (i>=1) is blanked if it and every higher digit is 0. In its slot, dig_an=1111 and bcd_out=0000.
  - The units digit is never blanked, so 0000 shows "0".
- Invariant: dig_an is never zero-hot-low in more than one bit; at most one anode is active at any time.
- Reset mid-count or mid-scan immediately returns every output to its reset value. No wrap or load_err pulse is produced by reset.

Test Plan:
1. CNT_DIV=1, SCAN_DIV=2, load 0x9998, en=1, up_dn=1 → count_val 9999 then 0000; wrap high exactly in the 0000 cycle; then 0001.
2. Load 0x0000, up_dn=0, en=1, CNT_DIV=1 → 9999 with wrap=1, then 9998. Load 0x1000, count down → 0999 (triple borrow correct).
3. Load 0x12AF → count_val 0x1200, load_err one-cycle pulse. Load and clr asserted together → 0000, load_err=0.
4. SCAN_DIV=2, count_val 0x0305 → dig_an cycles 1110/1101/1011/0111 with bcd_out 5/0/3/0, each slot 2 cycles. With blank_lz=1, the thousands slot gives dig_an=1111, bcd_out=0 while the tens slot still shows 0 with 1101.
5. CNT_DIV=4, en toggled 1,1,0,0,1,1 → exactly one increment, occurring after the 4th enabled cycle. The scan keeps running while en=0.
6. Drop rst_n asynchronously mid-count at 0x4321 → all outputs immediately at reset values; after release, counting resumes from 0000 and the scan starts at slot 0.
